bus_timer: RTL
==============

# bus_timer

Memory-mapped timer peripheral that responds to the RV32I core's data bus: the bus-target side of the core's load/store interface. It decodes `busWe`/`busAddr`/`busWData`/`busFunc3`, honours byte/half/word store lanes and returns sign- or zero-extended load data on `busRData` in the same cycle. Internally it runs a prescaled 32-bit up-counter with a compare match, sticky status flags and an interrupt output. The bus address decoder sits in front and drives `busSel`.

## Interface
Parameters:
- `PSC_W`, default 16: prescaler register width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `busSel`  in  1  this peripheral is addressed this cycle.
- `busWe`  in  1  store strobe; effective only when `busSel`=1.
- `busAddr`  in  32  byte address; only `[4:0]` are used.
- `busWData`  in  32  store data, LSB-aligned as the core drives it.
- `busFunc3`  in  3  RV32I load/store func3.
- `busRData`  out  32  load data, combinational.
- `timerIrq`  out  1  `IRQ_EN & MATCH`, driven from registers.

## Operation
Registers are selected by `busAddr[4:2]`:
- **0x00 CTRL:** `[0]` EN, `[1]` AUTO_RELOAD, `[2]` IRQ_EN. Other bits read 0.
- **0x04 PSC:** `[PSC_W-1:0]` prescale value. Any write also clears the internal prescale counter `pc`.
- **0x08 COUNT:** 32-bit, read/write.
- **0x0C CMP:** 32-bit, read/write.
- **0x10 STATUS:** `[0]` MATCH, `[1]` OVF. Both are sticky and write-1-to-clear.
- **0x14–0x1C:** read 0; writes are ignored.

Store lanes (write when `busSel & busWe`):
- **SB (000):** writes lane `addr[1:0]` from `wdata[7:0]`.
- **SH (001):** writes lanes `{addr[1],0}` and `{addr[1],1}` from `wdata[15:0]`.
- **SW (010):** writes all lanes.
- Misaligned SH (`addr[0]`=1), misaligned SW (`addr[1:0]`≠0) and any other func3 are ignored with no state change.
- For STATUS, W1C applies per written lane.

Loads (when `busSel`=1):
- The addressed word is read from current register state.
- **LB (000) / LBU (100):** byte at `addr[1:0]`, sign- or zero-extended.
- **LH (001) / LHU (101):** half at `addr[1]`, sign- or zero-extended.
- **LW (010):** the full word.
- Any other func3, or `busSel`=0: `busRData`=0.
- Misaligned loads return the aligned lane; no fault is raised.

Counting, only while EN=1:
- If `pc == PSC`: `pc` ← 0 and a tick fires; otherwise `pc` ← `pc`+1. PSC=0 gives a tick every cycle.
- On a tick with `COUNT == CMP`: MATCH ← 1, and COUNT ← 0 if AUTO_RELOAD, else COUNT+1.
- On a tick with `COUNT != CMP`: COUNT ← COUNT+1.
- A tick at `COUNT` = 0xFFFF_FFFF wraps COUNT to 0 and sets OVF.
- EN=0 holds both `pc` and COUNT.

## Timing
- **Reset:** all registers, `pc`, MATCH, OVF and `timerIrq` are 0. `busRData` follows its combinational rule (0 unless a load is selected).
- **Write latency:** a store is visible to a load in the next cycle. A same-cycle load returns the pre-write value.
- **`timerIrq`:** rises the cycle after the tick edge that sets MATCH. It falls the cycle after a W1C of MATCH or a clear of IRQ_EN.
- **Bus write to COUNT coinciding with a tick:** the bus write wins. Written lanes take `wdata`, unwritten lanes keep their old value, and there is no increment that cycle. The match check still uses the pre-write COUNT.
- **W1C coinciding with a hardware set** of the same flag: the set wins and the flag stays 1.
- **Write to PSC coinciding with a tick:** `pc` ← 0 and the tick still fires.
- **CTRL write clearing EN:** takes effect from the next cycle. The current-cycle tick still fires.
- **`rst` asserted mid-count:** everything returns to its reset value at that edge, with no pending tick.

## Structure
- Shared package `bus_pkg` holds:
  - func3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - timer register offsets `TMR_CTRL` … `TMR_STATUS`;
  - CTRL/STATUS bit-index constants.
- Sub-module `bus_lane_unit` (combinational) handles the func3/address lane logic shared with the data RAM:
  - outputs 4-bit write enable and replicated write data;
  - performs load extraction and extension.

## Test plan
- **Reset and register access:** after reset all reads return 0 and `timerIrq`=0. SW 0x1234_5678 to CMP, then LW returns 0x1234_5678; LB at offset 0x0F returns 0x0000_0012; LBU at 0x0C returns 0x78.
- **Sign extension:** SW 0x0000_80FF to CMP, then LB at 0x0C returns 0xFFFF_FFFF, LH at 0x0C returns 0xFFFF_80FF, and LHU at 0x0C returns 0x0000_80FF. SH to CMP at offset 0x0D is ignored and CMP is unchanged.
- **Prescale and match:** PSC=2, CMP=3, CTRL=0b111. COUNT increments every 3 cycles. MATCH and `timerIrq` go to 1 one cycle after the tick at COUNT=3, and COUNT returns to 0. W1C STATUS=1 clears `timerIrq` on the next cycle.
- **Overflow:** SW COUNT=0xFFFF_FFFE with PSC=0, CMP=0, EN=1, AUTO_RELOAD=0. After 2 cycles COUNT=0 and OVF=1; the next tick sets MATCH.
- **Collisions:** a bus write of COUNT=0x10 on a tick cycle gives COUNT=0x10 on the next cycle. A W1C of MATCH on the cycle MATCH is set leaves MATCH=1.
- **Reset mid-count:** assert `rst` for one cycle while COUNT=5 and `timerIrq`=1. All registers read 0 afterwards and counting stays halted.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for data-bus targets (timer peripheral, data RAM).
// Contents:
//   - RV32I load/store func3 encodings
//   - timer register word indices, compared against busAddr[4:2]
//   - CTRL / STATUS bit positions
//   - byte-lane mask helpers used to merge partial stores
package bus_pkg;

  // RV32I load/store func3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Timer register word indices (byte offset >> 2).
  localparam logic [2:0] TMR_CTRL   = 3'd0;  // 0x00
  localparam logic [2:0] TMR_PSC    = 3'd1;  // 0x04
  localparam logic [2:0] TMR_COUNT  = 3'd2;  // 0x08
  localparam logic [2:0] TMR_CMP    = 3'd3;  // 0x0C
  localparam logic [2:0] TMR_STATUS = 3'd4;  // 0x10

  // CTRL bit positions.
  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned CTRL_W           = 3;

  // STATUS bit positions.
  localparam int unsigned STATUS_MATCH = 0;
  localparam int unsigned STATUS_OVF   = 1;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Replace only the strobed byte lanes of old_word with new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = lane_mask(strb);
    return (old_word & ~m) | (new_word & m);
  endfunction

endpackage

// File: rtl/bus_lane_unit.sv
// Combinational byte-lane logic for an RV32I data-bus target.
// Stores: decodes func3 and the low address bits into a 4-bit lane strobe and
// replicates the LSB-aligned store data onto every lane. Misaligned or unknown
// stores yield an all-zero strobe so the target sees no write.
// Loads: extracts the addressed byte/half from the selected register word and
// sign- or zero-extends it. Misaligned loads return the aligned lane.
// Ports:
//   func3     in  3   load/store func3
//   addr_lo   in  2   byte address bits [1:0]
//   wdata     in  32  store data as driven by the core
//   rword     in  32  addressed register word (current state)
//   wstrb     out 4   byte write enables (not gated by select/we)
//   wdata_rep out 32  store data replicated across lanes
//   rdata     out 32  extended load data (0 for unknown func3)
module bus_lane_unit
  import bus_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    wstrb = 4'b0000;
    case (func3)
      F3_B: wstrb = 4'b0001 << addr_lo;
      F3_H: begin
        if (!addr_lo[0]) begin
          wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: begin
        if (addr_lo == 2'b00) begin
          wstrb = 4'b1111;
        end
      end
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    case (func3)
      F3_B:    wdata_rep = {4{wdata[7:0]}};
      F3_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // A misaligned half ignores addr[0] and returns the aligned half.
  assign sel_byte = rword[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata = 32'h0;
    case (func3)
      F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata = {24'h0, sel_byte};
      F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata = {16'h0, sel_half};
      F3_W:    rdata = rword;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer peripheral on the RV32I data bus.
// A prescaled 32-bit up-counter with compare match, sticky MATCH/OVF status
// (write-1-to-clear) and a level interrupt. Loads are answered combinationally
// from current register state; stores take effect at the next rising edge.
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   busSel    in  1   peripheral addressed this cycle
//   busWe     in  1   store strobe (qualified by busSel)
//   busAddr   in  32  byte address, [4:0] decoded
//   busWData  in  32  store data, LSB-aligned
//   busFunc3  in  3   load/store func3
//   busRData  out 32  load data (0 when not selected)
//   timerIrq  out 1   IRQ_EN & MATCH
module bus_timer
  import bus_pkg::*;
#(
  parameter int unsigned PSC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  busFunc3,
  output logic [31:0] busRData,
  output logic        timerIrq
);

  // Architectural state.
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [PSC_W-1:0]  pc_q, pc_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;

  // Bus decode.
  logic [2:0]  reg_idx;
  logic [31:0] rword;
  logic [3:0]  lane_strb;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] lane_rdata;
  logic        wr_ctrl, wr_psc, wr_count, wr_cmp, wr_status;

  // Counter datapath.
  logic en;
  logic tick;
  logic hit;
  logic wrap;
  logic w1c_match;
  logic w1c_ovf;

  // Only [4:0] of the address is decoded; the rest belongs to the decoder.
  logic unused_addr;
  assign unused_addr = ^busAddr[31:5];

  assign reg_idx = busAddr[4:2];

  // Current-state view of the addressed word; unmapped words read 0.
  always_comb begin
    rword = 32'h0;
    case (reg_idx)
      TMR_CTRL:   rword = 32'(ctrl_q);
      TMR_PSC:    rword = 32'(psc_q);
      TMR_COUNT:  rword = count_q;
      TMR_CMP:    rword = cmp_q;
      TMR_STATUS: rword = {30'h0, ovf_q, match_q};
      default:    rword = 32'h0;
    endcase
  end

  bus_lane_unit u_lane (
    .func3     (busFunc3),
    .addr_lo   (busAddr[1:0]),
    .wdata     (busWData),
    .rword     (rword),
    .wstrb     (lane_strb),
    .wdata_rep (wdata_rep),
    .rdata     (lane_rdata)
  );

  assign strb = (busSel && busWe) ? lane_strb : 4'b0000;

  assign wr_ctrl   = (reg_idx == TMR_CTRL)   && (strb != 4'b0000);
  assign wr_psc    = (reg_idx == TMR_PSC)    && (strb != 4'b0000);
  assign wr_count  = (reg_idx == TMR_COUNT)  && (strb != 4'b0000);
  assign wr_cmp    = (reg_idx == TMR_CMP)    && (strb != 4'b0000);
  assign wr_status = (reg_idx == TMR_STATUS) && (strb != 4'b0000);

  // Both status flags live in byte lane 0.
  assign w1c_match = wr_status && strb[0] && wdata_rep[STATUS_MATCH];
  assign w1c_ovf   = wr_status && strb[0] && wdata_rep[STATUS_OVF];

  // Tick and flag events are all computed from pre-write state, so a
  // same-cycle bus write never suppresses a tick or a flag set.
  assign en   = ctrl_q[CTRL_EN];
  assign tick = en && (pc_q == psc_q);
  assign hit  = tick && (count_q == cmp_q);
  assign wrap = tick && (count_q == 32'hFFFF_FFFF);

  always_comb begin
    ctrl_d  = ctrl_q;
    psc_d   = psc_q;
    pc_d    = pc_q;
    count_d = count_q;
    cmp_d   = cmp_q;

    // All CTRL bits are in lane 0.
    if (wr_ctrl && strb[0]) begin
      ctrl_d = wdata_rep[CTRL_W-1:0];
    end

    if (wr_psc) begin
      for (int i = 0; i < int'(PSC_W); i++) begin
        if (strb[i / 8]) begin
          psc_d[i] = wdata_rep[i];
        end
      end
    end

    // Any PSC write restarts the prescale period; the current tick (if any)
    // has already been decided from the old pc.
    if (wr_psc) begin
      pc_d = '0;
    end else if (en) begin
      pc_d = tick ? '0 : pc_q + PSC_W'(1);
    end

    // Bus write wins over the tick increment; unwritten lanes keep old value.
    if (wr_count) begin
      count_d = merge_lanes(count_q, wdata_rep, strb);
    end else if (tick) begin
      if (hit && ctrl_q[CTRL_AUTO_RELOAD]) begin
        count_d = 32'h0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_cmp) begin
      cmp_d = merge_lanes(cmp_q, wdata_rep, strb);
    end
  end

  // Hardware set takes priority over a coincident W1C.
  assign match_d = hit  || (match_q && !w1c_match);
  assign ovf_d   = wrap || (ovf_q && !w1c_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      psc_q   <= '0;
      pc_q    <= '0;
      count_q <= 32'h0;
      cmp_q   <= 32'h0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      psc_q   <= psc_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busRData = busSel ? lane_rdata : 32'h0;
  assign timerIrq = ctrl_q[CTRL_IRQ_EN] && match_q;

endmodule
